// File: rtl/prefix_classifier_rr_if.sv
// Handshake bundle for prefix_classifier_rr: per-channel input lanes plus the
// registered output stage. master = lane FIFOs / consumer side, slave = classifier.
interface prefix_classifier_rr_if #(
   parameter int NCH      = 4,
   parameter int DATA_W   = 4,
   parameter int PREFIX_W = 2
);
   localparam int CODE_W = (PREFIX_W + 1 > $clog2(DATA_W + 1)) ? PREFIX_W + 1 : $clog2(DATA_W + 1);
   localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]        in_valid;
   logic [NCH-1:0]        in_ready;
   logic [NCH*DATA_W-1:0] in_data;
   logic                  mode;
   logic                  out_valid;
   logic                  out_ready;
   logic [CODE_W-1:0]     out_code;
   logic [CH_W-1:0]       out_ch;

   modport master (
      output in_valid, in_data, mode, out_ready,
      input  in_ready, out_valid, out_code, out_ch
   );

   modport slave (
      input  in_valid, in_data, mode, out_ready,
      output in_ready, out_valid, out_code, out_ch
   );
endinterface

// File: rtl/prefix_classifier_rr.sv
// Round-robin multi-channel classifier: grants one lane per cycle, maps the word
// to a prefix or leading-one code, and holds it in a one-entry output register.
module prefix_classifier_rr #(
   parameter int NCH      = 4,
   parameter int DATA_W   = 4,
   parameter int PREFIX_W = 2,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   prefix_classifier_rr_if.slave bus,
   output logic [CNT_W-1:0] zero_cnt
);
   localparam int CODE_W = (PREFIX_W + 1 > $clog2(DATA_W + 1)) ? PREFIX_W + 1 : $clog2(DATA_W + 1);
   localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;

   logic [CH_W-1:0]   ptr;
   logic [CH_W-1:0]   gnt;
   logic [CH_W:0]     sum;
   logic [NCH-1:0]    vv;
   logic              gnt_found;
   logic              space;
   logic              accept;
   logic [DATA_W-1:0] word;
   logic [CODE_W-1:0] code_pfx;
   logic [CODE_W-1:0] code_pri;

   assign space = !bus.out_valid || bus.out_ready;

   // Rotate valids so bit 0 is the lane at ptr; first set bit wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt       = '0;
      sum       = '0;
      vv        = NCH'({bus.in_valid, bus.in_valid} >> ptr);
      for (int k = 0; k < NCH; k++) begin
         if (!gnt_found && vv[k]) begin
            gnt_found = 1'b1;
            sum       = {1'b0, ptr} + (CH_W+1)'(k);
            if (sum >= (CH_W+1)'(NCH)) sum = sum - (CH_W+1)'(NCH);
            gnt       = sum[CH_W-1:0];
         end
      end
   end

   assign accept       = gnt_found && space && !rst;
   assign bus.in_ready = accept ? (NCH'(1) << gnt) : '0;
   assign word         = DATA_W'(bus.in_data >> (int'(gnt) * DATA_W));

   always_comb begin
      code_pfx = CODE_W'(word[DATA_W-1 -: PREFIX_W]) + CODE_W'(1);
      code_pri = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (word[i]) code_pri = CODE_W'(i + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_code  <= '0;
         bus.out_ch    <= '0;
         ptr           <= '0;
         zero_cnt      <= '0;
      end else begin
         if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_code  <= bus.mode ? code_pri : code_pfx;
            bus.out_ch    <= gnt;
            ptr           <= (gnt == CH_W'(NCH - 1)) ? '0 : gnt + CH_W'(1);
            if (bus.mode && (word == '0) && (zero_cnt != '1))
               zero_cnt <= zero_cnt + CNT_W'(1);
         end else if (bus.out_ready) begin
            // Drain: code/channel keep their last value.
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_prefix_classifier_rr.sv
// Directed bench for prefix_classifier_rr: stimulus pushes hand-computed results
// into a scoreboard queue, a negedge monitor pops them as outputs are consumed.
module tb_prefix_classifier_rr;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   prefix_classifier_rr_if #(.NCH(4), .DATA_W(4), .PREFIX_W(2)) bus ();
   prefix_classifier_rr_if #(.NCH(4), .DATA_W(4), .PREFIX_W(2)) bus2 ();
   logic [7:0] zero_cnt;
   logic [1:0] zero_cnt2;

   prefix_classifier_rr #(.NCH(4), .DATA_W(4), .PREFIX_W(2), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .bus(bus), .zero_cnt(zero_cnt)
   );

   prefix_classifier_rr #(.NCH(4), .DATA_W(4), .PREFIX_W(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2), .zero_cnt(zero_cnt2)
   );

   typedef struct packed {
      logic [2:0] code;
      logic [1:0] ch;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic expect_out(input int code, input int ch);
      exp_t e;
      e.code = 3'(code);
      e.ch   = 2'(ch);
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL sb_unexpected: got ch %0d code %0d, expected no output",
                        bus.out_ch, bus.out_code);
            end else begin
               mon_e = sb.pop_front();
               check("sb_code", int'(bus.out_code), int'(mon_e.code));
               check("sb_ch", int'(bus.out_ch), int'(mon_e.ch));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "timeout");
   end

   int exp5[5] = '{1, 2, 3, 3, 3};

   initial begin
      rst = 1'b1;
      bus.in_valid  = 4'hF;
      bus.in_data   = '0;
      bus.mode      = 1'b0;
      bus.out_ready = 1'b0;
      bus2.in_valid  = '0;
      bus2.in_data   = '0;
      bus2.mode      = 1'b0;
      bus2.out_ready = 1'b0;
      step();
      step();
      @(negedge clk);
      check("rst_in_ready", int'(bus.in_ready), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_code", int'(bus.out_code), 0);
      check("rst_out_ch", int'(bus.out_ch), 0);
      check("rst_zero_cnt", int'(zero_cnt), 0);
      step();
      rst = 1'b0;
      bus.in_valid = '0;

      // T1: single prefix-mode word on ch0
      bus.mode      = 1'b0;
      bus.in_data   = 16'h0006;
      bus.in_valid  = 4'b0001;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("t1_in_ready", int'(bus.in_ready), 1);
      expect_out(2, 0);
      step();
      bus.in_valid = '0;
      @(negedge clk);
      check("t1_latency_valid", int'(bus.out_valid), 1);
      step();
      @(negedge clk);
      check("t1_drain_valid", int'(bus.out_valid), 0);
      check("t1_drain_code", int'(bus.out_code), 2);

      // T2: all lanes valid, fresh pointer
      bus.in_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.in_data  = 16'hFA50;
      bus.in_valid = 4'hF;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("t2_in_ready", int'(bus.in_ready), 1 << (i % 4));
         expect_out((i % 4) + 1, i % 4);
         step();
      end
      bus.in_valid = '0;
      @(negedge clk);
      step();
      @(negedge clk);
      check("t2_zero_cnt_mode0", int'(zero_cnt), 0);

      // T4: back-pressure hold, then resume at next lane
      step();
      bus.in_valid  = 4'hF;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("t4_first_grant", int'(bus.in_ready), 1);
      expect_out(1, 0);
      step();
      bus.out_ready = 1'b0;
      for (int h = 0; h < 3; h++) begin
         @(negedge clk);
         check("t4_hold_in_ready", int'(bus.in_ready), 0);
         check("t4_hold_valid", int'(bus.out_valid), 1);
         check("t4_hold_code", int'(bus.out_code), 1);
         check("t4_hold_ch", int'(bus.out_ch), 0);
         step();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("t4_resume_grant", int'(bus.in_ready), 2);
      expect_out(2, 1);
      step();
      bus.in_valid = '0;
      @(negedge clk);
      step();
      @(negedge clk);
      check("t4_drain_valid", int'(bus.out_valid), 0);
      check("t4_drain_code", int'(bus.out_code), 2);
      check("t4_drain_ch", int'(bus.out_ch), 1);

      // T3: priority mode on ch2
      step();
      bus.mode     = 1'b1;
      bus.in_valid = 4'b0100;
      bus.in_data  = 16'h0000;
      @(negedge clk);
      check("t3_in_ready_a", int'(bus.in_ready), 4);
      expect_out(0, 2);
      step();
      bus.in_data = 16'h0200;
      @(negedge clk);
      check("t3_in_ready_b", int'(bus.in_ready), 4);
      check("t3_zero_cnt_a", int'(zero_cnt), 1);
      expect_out(2, 2);
      step();
      bus.in_data = 16'h0800;
      @(negedge clk);
      check("t3_in_ready_c", int'(bus.in_ready), 4);
      expect_out(4, 2);
      step();
      bus.in_valid = '0;
      @(negedge clk);
      check("t3_zero_cnt_b", int'(zero_cnt), 1);

      // T6: reset while a word is held
      step();
      bus.in_valid  = 4'b0010;
      bus.in_data   = 16'h0000;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("t6_grant", int'(bus.in_ready), 2);
      step();
      bus.in_valid  = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("t6_held_valid", int'(bus.out_valid), 1);
      check("t6_zero_cnt", int'(zero_cnt), 2);
      step();
      rst = 1'b1;
      bus.in_valid = 4'hF;
      bus.in_data  = 16'h4444;
      @(negedge clk);
      check("t6_rst_in_ready", int'(bus.in_ready), 0);
      step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("t6_post_valid", int'(bus.out_valid), 0);
      check("t6_post_zero_cnt", int'(zero_cnt), 0);
      check("t6_post_grant", int'(bus.in_ready), 1);
      expect_out(3, 0);
      step();
      bus.in_valid = '0;
      @(negedge clk);
      step();

      // T5: saturating counter on the narrow-counter instance
      bus2.mode      = 1'b1;
      bus2.in_data   = '0;
      bus2.out_ready = 1'b1;
      bus2.in_valid  = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 4) bus2.in_valid = '0;
         @(negedge clk);
         check("t5_zero_cnt_sat", int'(zero_cnt2), exp5[k]);
      end

      step();
      step();
      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
